// File: rtl/bta_pipe_adder_if.sv
// ============================================================================
// Module      : bta_pipe_adder_if
// Description : Operand-in / sum-out handshake bundle for bta_pipe_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bta_pipe_adder_if #(
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_data;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    // Producer/consumer side: drives operands and downstream ready.
    modport master (
        output in_valid, in_data, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, in_data, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/bta_pipe_adder.sv
// ============================================================================
// Module      : bta_pipe_adder
// Description : Pipelined N-operand binary tree adder with valid/ready
//               stall propagation and multi-beat accumulate mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bta_pipe_adder #(
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int ACC_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    bta_pipe_adder_if.slave bus
);

    localparam int L = $clog2(N);

    // Bit offset of tree level lvl inside the packed w_tree bus.
    function automatic int f_off(input int lvl);
        int s;
        s = 0;
        for (int i = 1; i < lvl; i++) begin
            s += (N >> i) * (W + i);
        end
        return s;
    endfunction

    localparam int c_tot = f_off(L + 1);

    logic [c_tot-1:0]  w_tree;
    logic              w_advance;
    logic [L-1:0]      r_vld;
    logic [L-1:0]      r_tacc;
    logic [L-1:0]      r_tlast;

    logic [W+L-1:0]    w_top;
    logic [ACC_W-1:0]  w_top_ext;
    logic [ACC_W-1:0]  w_base;
    logic [ACC_W:0]    w_grp;
    logic              w_grp_ovf;

    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_sum;
    logic              r_out_ovf;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              r_acc_open;

    // Whole pipe moves in lockstep; depends only on output-side state.
    assign w_advance = !r_out_valid || bus.out_ready;

    generate
        for (genvar gi = 1; gi <= L; gi++) begin : g_lvl
            localparam int c_cnt   = N >> gi;
            localparam int c_w     = W + gi;
            localparam bit c_first = (gi == 1);

            logic [2*c_cnt*(c_w-1)-1:0] w_src;
            logic [c_cnt*c_w-1:0]       r_lvl;

            if (gi == 1) begin : g_from_in
                assign w_src = bus.in_data;
            end else begin : g_from_lvl
                assign w_src = w_tree[f_off(gi-1) +: 2*c_cnt*(c_w-1)];
            end

            // Each node grows by one bit so the sum never truncates.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lvl <= '0;
                end else if (w_advance && (!c_first || bus.in_valid)) begin
                    for (int j = 0; j < c_cnt; j++) begin
                        r_lvl[j*c_w +: c_w] <= {1'b0, w_src[2*j*(c_w-1) +: c_w-1]}
                                             + {1'b0, w_src[(2*j+1)*(c_w-1) +: c_w-1]};
                    end
                end
            end

            assign w_tree[f_off(gi) +: c_cnt*c_w] = r_lvl;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_tacc  <= '0;
            r_tlast <= '0;
        end else if (w_advance) begin
            r_vld[0]   <= bus.in_valid;
            r_tacc[0]  <= bus.in_acc;
            r_tlast[0] <= bus.in_last;
            for (int i = 1; i < L; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_tacc[i]  <= r_tacc[i-1];
                r_tlast[i] <= r_tlast[i-1];
            end
        end
    end

    assign w_top     = w_tree[f_off(L) +: W+L];
    assign w_top_ext = ACC_W'(w_top);
    assign w_base    = r_acc_open ? r_acc : '0;
    assign w_grp     = {1'b0, w_base} + {1'b0, w_top_ext};
    assign w_grp_ovf = (r_acc_open & r_ovf) | w_grp[ACC_W];

    // Plain beats bypass the accumulator so an open group survives them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_acc_open  <= 1'b0;
        end else if (w_advance) begin
            if (!r_vld[L-1]) begin
                r_out_valid <= 1'b0;
            end else if (!r_tacc[L-1]) begin
                r_out_sum   <= w_top_ext;
                r_out_ovf   <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (!r_tlast[L-1]) begin
                r_acc       <= w_grp[ACC_W-1:0];
                r_ovf       <= w_grp_ovf;
                r_acc_open  <= 1'b1;
                r_out_valid <= 1'b0;
            end else begin
                r_out_sum   <= w_grp[ACC_W-1:0];
                r_out_ovf   <= w_grp_ovf;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_ovf       <= 1'b0;
                r_acc_open  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bta_pipe_adder.sv
// ============================================================================
// Module      : tb_bta_pipe_adder
// Description : Self-checking bench for bta_pipe_adder (default + sweep configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bta_pipe_adder;

    localparam longint MOD = 64'd1 << 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bta_pipe_adder_if #(.W(16), .N(8),  .ACC_W(24)) bus ();
    bta_pipe_adder_if #(.W(4),  .N(2),  .ACC_W(5))  b2 ();
    bta_pipe_adder_if #(.W(8),  .N(16), .ACC_W(12)) b16 ();

    bta_pipe_adder #(.W(16), .N(8),  .ACC_W(24)) dut   (.clk(clk), .rst(rst), .bus(bus));
    bta_pipe_adder #(.W(4),  .N(2),  .ACC_W(5))  dut2  (.clk(clk), .rst(rst), .bus(b2));
    bta_pipe_adder #(.W(8),  .N(16), .ACC_W(12)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    int n_vec = 0;
    int n_err = 0;

    logic [24:0] exp_q[$];
    logic [24:0] obs[$];
    longint      m_acc = 0;
    bit          m_ovf = 1'b0;
    int          run = 0, max_run = 0, stalls = 0;
    bit          bp_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_sum;
    logic        prev_ovf;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    function automatic longint tree_sum(input logic [127:0] d);
        longint s = 0;
        for (int k = 0; k < 8; k++) s += longint'(d[k*16 +: 16]);
        return s;
    endfunction

    function automatic logic [127:0] fill(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [127:0] ramp(input int b);
        logic [127:0] d;
        for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'(b + k);
        return d;
    endfunction

    // Downstream ready: random while backpressure is enabled.
    always @(posedge clk) begin
        #1;
        bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model plus compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        logic [24:0] e;
        longint t, s;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_sum", bus.out_sum, 0);
            chk("rst_out_ovf", bus.out_ovf, 0);
            exp_q.delete();
            m_acc = 0;
            m_ovf = 1'b0;
            prev_stall = 1'b0;
            run = 0;
        end else begin
            chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_sum", bus.out_sum, prev_sum);
                chk("hold_ovf", bus.out_ovf, prev_ovf);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_out");
                end else begin
                    e = exp_q[0];
                    chk("out_sum", bus.out_sum, e[23:0]);
                    chk("out_ovf", bus.out_ovf, e[24]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        obs.push_back({bus.out_ovf, bus.out_sum});
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (bus.out_valid && !bus.out_ready) stalls++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.out_sum;
            prev_ovf   = bus.out_ovf;

            if (bus.in_valid && bus.in_ready) begin
                t = tree_sum(bus.in_data);
                if (!bus.in_acc) begin
                    exp_q.push_back({1'b0, 24'(t)});
                end else begin
                    s = m_acc + t;
                    if (bus.in_last) begin
                        exp_q.push_back({m_ovf | (s >= MOD), 24'(s % MOD)});
                        m_acc = 0;
                        m_ovf = 1'b0;
                    end else begin
                        m_ovf = m_ovf | (s >= MOD);
                        m_acc = s % MOD;
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] d, input bit acc, input bit last);
        int g;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_acc   = acc;
        bus.in_last  = last;
        g = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            g++;
            if (g > 200) begin
                fail("send_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {4{$urandom}};
        bus.in_acc   = 1'($urandom_range(0, 1));
        bus.in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Counts negedges from the accepting edge until out_valid appears.
    task automatic wait_out(input string nm, input int lat, input longint sum, input bit ovf);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 50);
        chk({nm, "_lat"}, k, lat);
        chk({nm, "_sum"}, bus.out_sum, sum);
        chk({nm, "_ovf"}, bus.out_ovf, ovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k;
        logic [24:0] v;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_acc = 1'b0; bus.in_last = 1'b0;
        b2.in_valid  = 1'b0; b2.in_data  = '0; b2.in_acc  = 1'b0; b2.in_last  = 1'b0; b2.out_ready  = 1'b1;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_acc = 1'b0; b16.in_last = 1'b0; b16.out_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus.in_ready, 1);

        // Plain sums with latency pin
        send(fill(16'hFFFF), 1'b0, 1'b0);
        wait_out("plain_ffff", 4, 24'h07FFF8, 1'b0);
        drain();
        send(ramp(1), 1'b0, 1'b0);
        wait_out("plain_1to8", 4, 36, 1'b0);
        drain();

        // Streaming at full rate
        base = obs.size();
        for (int b = 0; b < 20; b++) send(ramp(b), 1'b0, 1'b0);
        drain();
        chk("stream_count", obs.size() - base, 20);
        for (int i = 0; i < 20; i++) begin
            v = obs[base + i];
            chk("stream_val", v[23:0], 8 * i + 28);
        end
        chk("stream_no_bubble", max_run >= 20, 1);

        // Accumulate group with interleaved plain beat
        base = obs.size();
        send(fill(16'd1), 1'b1, 1'b0);
        send(fill(16'd1), 1'b1, 1'b0);
        send(fill(16'd2), 1'b0, 1'b0);
        send(fill(16'd1), 1'b1, 1'b1);
        drain();
        chk("acc_count", obs.size() - base, 2);
        v = obs[base];
        chk("acc_plain_mid", v, {1'b0, 24'd16});
        v = obs[base + 1];
        chk("acc_group", v, {1'b0, 24'd24});

        // Accumulator overflow
        base = obs.size();
        for (int b = 0; b < 33; b++) send(fill(16'hFFFF), 1'b1, b == 32);
        drain();
        chk("ovf_count", obs.size() - base, 1);
        v = obs[base];
        chk("ovf_sum", v[23:0], 524024);
        chk("ovf_flag", v[24], 1);

        // Backpressure
        base = obs.size();
        bp_en = 1'b1;
        for (int b = 0; b < 10; b++) send(ramp(7 * b), 1'b0, 1'b0);
        drain();
        bp_en = 1'b0;
        chk("bp_count", obs.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            v = obs[base + i];
            chk("bp_val", v[23:0], 56 * i + 28);
        end
        chk("bp_stalls_seen", stalls > 0, 1);
        @(posedge clk);
        #1;

        // Reset with an open group and beats in flight
        send(fill(16'd1), 1'b1, 1'b0);
        for (int b = 0; b < 5; b++) send(ramp(b), 1'b0, 1'b0);
        chk("pre_reset_valid", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1 chk("reset_drops_valid", bus.out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", bus.in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        send(fill(16'd1), 1'b1, 1'b1);
        wait_out("post_reset_group", 4, 8, 1'b0);
        drain();

        // Config sweep: N=2, W=4
        b2.in_valid = 1'b1;
        b2.in_data  = 8'hFF;
        @(negedge clk);
        chk("n2_in_ready", b2.in_ready, 1);
        @(posedge clk);
        #1 b2.in_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!b2.out_valid && k < 50);
        chk("n2_lat", k, 2);
        chk("n2_sum", b2.out_sum, 30);
        chk("n2_ovf", b2.out_ovf, 0);
        @(posedge clk);
        #1;

        // Config sweep: N=16, W=8
        b16.in_valid = 1'b1;
        b16.in_data  = {16{8'hFF}};
        @(negedge clk);
        chk("n16_in_ready", b16.in_ready, 1);
        @(posedge clk);
        #1 b16.in_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!b16.out_valid && k < 50);
        chk("n16_lat", k, 5);
        chk("n16_sum", b16.out_sum, 4080);
        chk("n16_ovf", b16.out_ovf, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
